// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types: memory op encoding, MEM stage state,
// MEM/WB register bundle and load/store funct3 encodings.
package rv32i_types;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'b00,
    MEM_LOAD  = 2'b01,
    MEM_STORE = 2'b10
  } mem_op_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } mem_stage_state_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [63:0] order;
    logic [4:0]  rd_s;
    logic [31:0] rd_v;
    logic        regf_we;
    logic        misalign;
  } mem_wb_reg_t;

  localparam logic [2:0] load_f3_lb  = 3'b000;
  localparam logic [2:0] load_f3_lh  = 3'b001;
  localparam logic [2:0] load_f3_lw  = 3'b010;
  localparam logic [2:0] load_f3_lbu = 3'b100;
  localparam logic [2:0] load_f3_lhu = 3'b101;

  localparam logic [2:0] store_f3_sb = 3'b000;
  localparam logic [2:0] store_f3_sh = 3'b001;
  localparam logic [2:0] store_f3_sw = 3'b010;

endpackage

// File: rtl/mem_align.sv
// Byte-lane alignment for data memory: masks, store lane shift,
// misalignment detection and load extraction/extension.
module mem_align
  import rv32i_types::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_off,
  input  logic        i_store,
  input  logic [31:0] i_store_data,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_rmask,
  output logic [3:0]  o_wmask,
  output logic [31:0] o_wdata,
  output logic        o_misalign,
  output logic [31:0] o_load_val
);

  logic [3:0]  w_base;
  logic [3:0]  w_mask;
  logic [31:0] w_sh;

  always_comb begin
    w_base     = 4'b1111;
    o_misalign = 1'b1;
    case (i_funct3[1:0])
      2'b00: begin
        w_base     = 4'b0001;
        o_misalign = 1'b0;
      end
      2'b01: begin
        w_base     = 4'b0011;
        o_misalign = i_off[0];
      end
      2'b10: begin
        w_base     = 4'b1111;
        o_misalign = (i_off != 2'b00);
      end
      default: ;
    endcase
  end

  assign w_mask  = w_base << i_off;
  assign o_rmask = i_store ? 4'b0000 : w_mask;
  assign o_wmask = i_store ? w_mask : 4'b0000;
  assign o_wdata = i_store_data << {i_off, 3'b000};

  // Selected lane is moved down to bit 0 before extension
  assign w_sh = i_rdata >> {i_off, 3'b000};

  always_comb begin
    o_load_val = i_rdata;
    case (i_funct3)
      load_f3_lb:  o_load_val = {{24{w_sh[7]}}, w_sh[7:0]};
      load_f3_lbu: o_load_val = {24'd0, w_sh[7:0]};
      load_f3_lh:  o_load_val = {{16{w_sh[15]}}, w_sh[15:0]};
      load_f3_lhu: o_load_val = {16'd0, w_sh[15:0]};
      default:     o_load_val = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// RV32I MEM stage: issues dmem requests, waits for response, fills MEM/WB.
// Optional RVFI memory outputs under MEM_STAGE_RVFI_EN.
module mem_stage
  import rv32i_types::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_inst,
  input  logic [63:0] in_order,
  input  logic [4:0]  in_rd_s,
  input  logic [31:0] in_rd_v,
  input  logic        in_regf_we,
  input  logic [1:0]  in_mem_op,
  input  logic [2:0]  in_funct3,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_store_data,
  output logic        mem_stall,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_rmask,
  output logic [3:0]  dmem_wmask,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_resp,
  output logic        wb_valid,
  output logic [31:0] wb_pc,
  output logic [31:0] wb_inst,
  output logic [63:0] wb_order,
  output logic [4:0]  wb_rd_s,
  output logic [31:0] wb_rd_v,
  output logic        wb_regf_we,
  output logic        wb_misalign,
`ifdef MEM_STAGE_RVFI_EN
  output logic [31:0] wb_mem_addr,
  output logic [3:0]  wb_mem_rmask,
  output logic [3:0]  wb_mem_wmask,
  output logic [31:0] wb_mem_rdata,
  output logic [31:0] wb_mem_wdata,
`endif
  output logic        timeout_err
);

  mem_stage_state_t r_state;
  mem_wb_reg_t      r_wb;

  logic [31:0] r_addr, r_wdata;
  logic [3:0]  r_rmask, r_wmask;
  logic [31:0] r_pc, r_inst;
  logic [63:0] r_order;
  logic [4:0]  r_rd_s;
  logic        r_we, r_store;
  logic [2:0]  r_f3;
  logic [1:0]  r_off;
  logic [31:0] r_tcnt;
  logic        r_terr;

`ifdef MEM_STAGE_RVFI_EN
  logic [31:0] r_m_addr, r_m_rdata, r_m_wdata;
  logic [3:0]  r_m_rmask, r_m_wmask;
`endif

  logic        w_wait, w_mem, w_store, w_we_in, w_mis;
  logic [2:0]  w_f3;
  logic [1:0]  w_off;
  logic [3:0]  w_rmask, w_wmask;
  logic [31:0] w_wdata, w_ld;

  assign w_wait  = (r_state == S_WAIT);
  assign w_mem   = (in_mem_op == MEM_LOAD) || (in_mem_op == MEM_STORE);
  assign w_store = w_wait ? r_store : (in_mem_op == MEM_STORE);
  assign w_f3    = w_wait ? r_f3 : in_funct3;
  assign w_off   = w_wait ? r_off : in_addr[1:0];
  assign w_we_in = in_regf_we && (in_rd_s != 5'd0);

  mem_align u_align (
    .i_funct3     (w_f3),
    .i_off        (w_off),
    .i_store      (w_store),
    .i_store_data (in_store_data),
    .i_rdata      (dmem_rdata),
    .o_rmask      (w_rmask),
    .o_wmask      (w_wmask),
    .o_wdata      (w_wdata),
    .o_misalign   (w_mis),
    .o_load_val   (w_ld)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_wb    <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rmask <= '0;
      r_wmask <= '0;
      r_pc    <= '0;
      r_inst  <= '0;
      r_order <= '0;
      r_rd_s  <= '0;
      r_we    <= 1'b0;
      r_store <= 1'b0;
      r_f3    <= '0;
      r_off   <= '0;
      r_tcnt  <= '0;
      r_terr  <= 1'b0;
`ifdef MEM_STAGE_RVFI_EN
      r_m_addr  <= '0;
      r_m_rdata <= '0;
      r_m_wdata <= '0;
      r_m_rmask <= '0;
      r_m_wmask <= '0;
`endif
    end else if (!w_wait) begin
      r_wb.valid <= 1'b0;
`ifdef MEM_STAGE_RVFI_EN
      r_m_addr  <= '0;
      r_m_rdata <= '0;
      r_m_wdata <= '0;
      r_m_rmask <= '0;
      r_m_wmask <= '0;
`endif
      if (in_valid && !w_mem) begin
        r_wb <= '{valid: 1'b1, pc: in_pc, inst: in_inst,
                  order: in_order, rd_s: in_rd_s, rd_v: in_rd_v,
                  regf_we: w_we_in, misalign: 1'b0};
      end else if (in_valid && w_mis) begin
        r_wb <= '{valid: 1'b1, pc: in_pc, inst: in_inst,
                  order: in_order, rd_s: in_rd_s, rd_v: 32'd0,
                  regf_we: 1'b0, misalign: 1'b1};
      end else if (in_valid) begin
        r_state <= S_WAIT;
        r_addr  <= {in_addr[31:2], 2'b00};
        r_rmask <= w_rmask;
        r_wmask <= w_wmask;
        r_wdata <= w_wdata;
        r_pc    <= in_pc;
        r_inst  <= in_inst;
        r_order <= in_order;
        r_rd_s  <= in_rd_s;
        r_we    <= w_we_in && !w_store;
        r_store <= w_store;
        r_f3    <= in_funct3;
        r_off   <= in_addr[1:0];
        r_tcnt  <= '0;
      end
    end else if (dmem_resp) begin
      r_state <= S_IDLE;
      r_wb <= '{valid: 1'b1, pc: r_pc, inst: r_inst,
                order: r_order, rd_s: r_rd_s,
                rd_v: r_store ? 32'd0 : w_ld,
                regf_we: r_we, misalign: 1'b0};
`ifdef MEM_STAGE_RVFI_EN
      r_m_addr  <= r_addr;
      r_m_rdata <= dmem_rdata;
      r_m_wdata <= r_wdata;
      r_m_rmask <= r_rmask;
      r_m_wmask <= r_wmask;
`endif
      r_addr  <= '0;
      r_rmask <= '0;
      r_wmask <= '0;
      r_wdata <= '0;
    end else begin
      r_wb.valid <= 1'b0;
      if (r_tcnt != 32'hFFFF_FFFF)
        r_tcnt <= r_tcnt + 32'd1;
      // Sticky until reset; the access itself keeps waiting
      if (TIMEOUT_CYCLES != 0 && r_tcnt + 32'd1 == 32'(TIMEOUT_CYCLES))
        r_terr <= 1'b1;
    end
  end

  assign mem_stall   = w_wait;
  assign dmem_addr   = r_addr;
  assign dmem_rmask  = r_rmask;
  assign dmem_wmask  = r_wmask;
  assign dmem_wdata  = r_wdata;
  assign wb_valid    = r_wb.valid;
  assign wb_pc       = r_wb.pc;
  assign wb_inst     = r_wb.inst;
  assign wb_order    = r_wb.order;
  assign wb_rd_s     = r_wb.rd_s;
  assign wb_rd_v     = r_wb.rd_v;
  assign wb_regf_we  = r_wb.regf_we;
  assign wb_misalign = r_wb.misalign;
  assign timeout_err = r_terr;

`ifdef MEM_STAGE_RVFI_EN
  assign wb_mem_addr  = r_m_addr;
  assign wb_mem_rmask = r_m_rmask;
  assign wb_mem_wmask = r_m_wmask;
  assign wb_mem_rdata = r_m_rdata;
  assign wb_mem_wdata = r_m_wdata;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed ALU, load, store,
// misaligned, timeout and reset-in-WAIT vectors.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_pc, in_inst, in_rd_v, in_addr, in_store_data;
  logic [63:0] in_order;
  logic [4:0]  in_rd_s;
  logic        in_regf_we;
  logic [1:0]  in_mem_op;
  logic [2:0]  in_funct3;
  logic        mem_stall;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_rmask, dmem_wmask;
  logic        dmem_resp;
  logic        wb_valid, wb_regf_we, wb_misalign, timeout_err;
  logic [31:0] wb_pc, wb_inst, wb_rd_v;
  logic [63:0] wb_order;
  logic [4:0]  wb_rd_s;
`ifdef MEM_STAGE_RVFI_EN
  logic [31:0] wb_mem_addr, wb_mem_rdata, wb_mem_wdata;
  logic [3:0]  wb_mem_rmask, wb_mem_wmask;
`endif

  mem_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_pc(in_pc), .in_inst(in_inst),
    .in_order(in_order), .in_rd_s(in_rd_s), .in_rd_v(in_rd_v),
    .in_regf_we(in_regf_we), .in_mem_op(in_mem_op),
    .in_funct3(in_funct3), .in_addr(in_addr),
    .in_store_data(in_store_data), .mem_stall(mem_stall),
    .dmem_addr(dmem_addr), .dmem_rmask(dmem_rmask),
    .dmem_wmask(dmem_wmask), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
    .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_inst(wb_inst),
    .wb_order(wb_order), .wb_rd_s(wb_rd_s), .wb_rd_v(wb_rd_v),
    .wb_regf_we(wb_regf_we), .wb_misalign(wb_misalign),
`ifdef MEM_STAGE_RVFI_EN
    .wb_mem_addr(wb_mem_addr), .wb_mem_rmask(wb_mem_rmask),
    .wb_mem_wmask(wb_mem_wmask), .wb_mem_rdata(wb_mem_rdata),
    .wb_mem_wdata(wb_mem_wdata),
`endif
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] order;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] rd_v;
    logic        chk_rdv;
    logic        we;
    logic        mis;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          n_chk = 0;
  int          n_fail = 0;
  logic [63:0] ord_ctr = 64'h100;
  logic [31:0] pc_ctr = 32'h8000_0000;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && wb_valid) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL wb_extra: got order %h expected none", wb_order);
      end else begin
        e = sb.pop_front();
        chk("wb_order", wb_order, e.order);
        chk("wb_pc", wb_pc, e.pc);
        chk("wb_inst", wb_inst, e.inst);
        chk("wb_regf_we", wb_regf_we, e.we);
        chk("wb_misalign", wb_misalign, e.mis);
        if (e.chk_rdv) chk("wb_rd_v", wb_rd_v, e.rd_v);
      end
    end
  end

  task automatic drive(input logic [1:0] op, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] sd,
                       input logic [31:0] rdv, input logic [4:0] rd,
                       input logic we);
    in_valid      = 1'b1;
    in_pc         = pc_ctr;
    in_inst       = pc_ctr ^ 32'hA5A5_0000;
    in_order      = ord_ctr;
    in_rd_s       = rd;
    in_rd_v       = rdv;
    in_regf_we    = we;
    in_mem_op     = op;
    in_funct3     = f3;
    in_addr       = addr;
    in_store_data = sd;
  endtask

  task automatic push(input logic [31:0] rdv, input logic chkv,
                      input logic we, input logic mis);
    exp_t x;
    x.order = ord_ctr; x.pc = pc_ctr; x.inst = pc_ctr ^ 32'hA5A5_0000;
    x.rd_v = rdv; x.chk_rdv = chkv; x.we = we; x.mis = mis;
    sb.push_back(x);
    ord_ctr = ord_ctr + 64'd1;
    pc_ctr  = pc_ctr + 32'd4;
  endtask

  task automatic alu(input logic [4:0] rd, input logic [31:0] rdv,
                     input logic we, input logic exp_we);
    drive(2'b00, 3'b000, 32'h0, 32'h0, rdv, rd, we);
    push(rdv, 1'b1, exp_we, 1'b0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("alu_stall", mem_stall, 1'b0);
  endtask

  task automatic mem(input logic [1:0] op, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] sd,
                     input int dly, input logic [31:0] rdata,
                     input logic [31:0] x_addr, input logic [3:0] x_rm,
                     input logic [3:0] x_wm, input logic [31:0] x_wd,
                     input logic [31:0] x_rdv, input logic x_we);
    drive(op, f3, addr, sd, 32'hDEAD_0000, 5'd9, 1'b1);
    push(x_rdv, 1'b1, x_we, 1'b0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i <= dly; i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
      end
      chk("wait_stall", mem_stall, 1'b1);
      chk("wait_wb_valid", wb_valid, 1'b0);
      chk("dmem_addr", dmem_addr, x_addr);
      chk("dmem_rmask", dmem_rmask, x_rm);
      chk("dmem_wmask", dmem_wmask, x_wm);
      if (op == 2'b10) chk("dmem_wdata", dmem_wdata, x_wd);
    end
    dmem_resp  = 1'b1;
    dmem_rdata = rdata;
    @(posedge clk); #1;
    dmem_resp  = 1'b0;
    dmem_rdata = 32'h0;
    chk("post_stall", mem_stall, 1'b0);
    chk("post_masks", {dmem_rmask, dmem_wmask}, 8'h00);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_pc = '0; in_inst = '0; in_order = '0;
    in_rd_s = '0; in_rd_v = '0; in_regf_we = 1'b0;
    in_mem_op = '0; in_funct3 = '0; in_addr = '0; in_store_data = '0;
    dmem_rdata = '0; dmem_resp = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wb_valid", wb_valid, 1'b0);
    chk("rst_stall", mem_stall, 1'b0);
    chk("rst_masks", {dmem_rmask, dmem_wmask}, 8'h00);
    chk("rst_timeout", timeout_err, 1'b0);
    chk("rst_wb_order", wb_order, 64'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    alu(5'd5, 32'h1234, 1'b1, 1'b1);
    alu(5'd0, 32'h55, 1'b1, 1'b0);
    mem(2'b01, 3'b000, 32'h1003, 32'h0, 0, 32'h80FF_FFFF,
        32'h1000, 4'b1000, 4'b0000, 32'h0, 32'hFFFF_FF80, 1'b1);
    mem(2'b01, 3'b100, 32'h1003, 32'h0, 0, 32'h80FF_FFFF,
        32'h1000, 4'b1000, 4'b0000, 32'h0, 32'h0000_0080, 1'b1);
    mem(2'b10, 3'b001, 32'h2002, 32'hABCD_1234, 3, 32'hFFFF_FFFF,
        32'h2000, 4'b0000, 4'b1100, 32'h1234_0000, 32'h0, 1'b0);

    drive(2'b01, 3'b010, 32'h3001, 32'h0, 32'h0, 5'd4, 1'b1);
    push(32'h0, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("mis_masks", {dmem_rmask, dmem_wmask}, 8'h00);
    chk("mis_stall", mem_stall, 1'b0);

    mem(2'b01, 3'b010, 32'h5000, 32'h0, 0, 32'hDEAD_BEEF,
        32'h5000, 4'b1111, 4'b0000, 32'h0, 32'hDEAD_BEEF, 1'b1);
    mem(2'b01, 3'b001, 32'h5002, 32'h0, 1, 32'h8001_1234,
        32'h5000, 4'b1100, 4'b0000, 32'h0, 32'hFFFF_8001, 1'b1);
    alu(5'd7, 32'h77, 1'b1, 1'b1);
    @(posedge clk); #1;

    drive(2'b01, 3'b010, 32'h4000, 32'h0, 32'h0, 5'd2, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("timeout_early", timeout_err, 1'b0);
    @(posedge clk); #1;
    chk("timeout_set", timeout_err, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    chk("timeout_hold", timeout_err, 1'b1);
    chk("timeout_stall", mem_stall, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_masks", {dmem_rmask, dmem_wmask}, 8'h00);
    chk("arst_addr", dmem_addr, 32'h0);
    chk("arst_stall", mem_stall, 1'b0);
    chk("arst_timeout", timeout_err, 1'b0);
    chk("arst_wb_order", wb_order, 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    alu(5'd1, 32'hCAFE, 1'b1, 1'b1);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory stage of the RV32I 5-stage pipeline. It is the consumer of the EX/MEM register: it accepts one instruction per cycle from EX and issues data-memory load/store requests.
- It holds each request stable until the memory responds, then aligns and sign-extends load data.
- It presents a registered MEM/WB result to writeback.
- It stalls upstream while a memory access is outstanding.

Parameters:
- TIMEOUT_CYCLES, 255: number of WAIT cycles without dmem_resp before timeout_err sets; 0 disables the counter.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- in_valid  input  1  EX/MEM entry valid
- in_pc  input  32  instruction PC
- in_inst  input  32  instruction word
- in_order  input  64  retirement order tag
- in_rd_s  input  5  destination register
- in_rd_v  input  32  EX result (ALU / lui / auipc)
- in_regf_we  input  1  writeback enable from EX
- in_mem_op  input  2  mem_op_t: none / load / store
- in_funct3  input  3  load/store width and sign
- in_addr  input  32  effective byte address (rs1 + imm)
- in_store_data  input  32  rs2 value
- mem_stall  output  1  high: upstream holds its EX/MEM register
- dmem_addr  output  32  word-aligned address
- dmem_rmask  output  4  byte read mask
- dmem_wmask  output  4  byte write mask
- dmem_wdata  output  32  lane-shifted store data
- dmem_rdata  input  32  read data, valid with dmem_resp
- dmem_resp  input  1  access complete
- wb_valid, wb_pc, wb_inst, wb_order, wb_rd_s, wb_rd_v, wb_regf_we  output  1/32/32/64/5/32/1  registered MEM/WB register
- wb_misalign  output  1  registered: access was misaligned and was suppressed
- timeout_err  output  1  sticky memory timeout flag

Behaviour:
Reset and state encoding:
- Reset is asynchronous and active-high. On reset, every output is 0 and the state is IDLE.
- States are IDLE and WAIT.

IDLE:
- mem_stall=0. All dmem masks are 0.
- If in_valid and in_mem_op=none: the MEM/WB register loads the pass-through fields and wb_valid=1 on the next cycle.
- wb_regf_we = in_regf_we and (in_rd_s != 0).
- If in_valid and the op is a load or store:
  - Compute off = in_addr[1:0].
  - Legal accesses: b at any offset; h at off 0 or 2; w at off 0.
  - Legal access: latch the request registers and the instruction fields, go to WAIT. wb_valid=0 on the next cycle.
  - Misaligned access: no request is issued. The next cycle has wb_valid=1, wb_regf_we=0, wb_misalign=1.
- If in_valid=0: wb_valid=0 on the next cycle.

WAIT:
- dmem_* outputs are driven only from the request registers and are held stable until the response arrives.
- dmem_addr = {addr[31:2], 2'b00}.
- rmask values:
  - lb/lbu: 0001<<off
  - lh/lhu: 0011<<off
  - lw: 1111
  - 0 for stores
- wmask values: sb 0001<<off, sh 0011<<off, sw 1111; 0 for loads.
- wdata = store_data << (8*off).
- mem_stall=1 for every WAIT cycle, including the cycle in which dmem_resp arrives.
- On dmem_resp the MEM/WB register loads the latched fields, then the state returns to IDLE.
  - Load: wb_rd_v = the selected byte or halfword, sign- or zero-extended per funct3.
  - Store: wb_rd_v = 0 and wb_regf_we=0.
  - wb_valid=1 on the next cycle.
- Cycles in WAIT without a response produce wb_valid=0.

Latency and throughput:
- Non-memory instruction: 1 cycle.
- Memory access whose response arrives in the first WAIT cycle: result visible 2 cycles after acceptance.
- The cycle after the response is always IDLE. This creates exactly one accept bubble per memory access.

Timeout counter:
- Clears on entry to WAIT and increments each WAIT cycle.
- When it reaches TIMEOUT_CYCLES (and TIMEOUT_CYCLES != 0), timeout_err sets and holds until reset. The state remains WAIT.

Reset in WAIT:
- The access is abandoned and the masks drop to 0 asynchronously.

Optional Feature:
- Macro: MEM_STAGE_RVFI_EN.
- When defined, registered outputs wb_mem_addr[31:0], wb_mem_rmask[3:0], wb_mem_wmask[3:0], wb_mem_rdata[31:0] and wb_mem_wdata[31:0] are added.
  - They carry the issued request and the response data alongside the wb_* fields for the RVFI monitor.
  - All are 0 for non-memory instructions and misaligned accesses, and 0 after reset.
- When not defined, these ports and registers do not exist.

Decomposition:
- rv32i_types gains:
  - mem_op_t (none=2'b00, load=2'b01, store=2'b10)
  - mem_stage_state_t (IDLE, WAIT)
  - mem_wb_reg_t covering the wb_* fields
- The existing load_f3_* and store_f3_* encodings are reused.
- One combinational sub-module, mem_align, produces rmask/wmask/wdata/misalign from (funct3, off, store_data) and the extended load value from (funct3, off, rdata).

Test Plan:
- Non-memory op, rd_s=5, rd_v=32'h1234 -> next cycle wb_valid=1, wb_rd_v=32'h1234, wb_regf_we=1, mem_stall stays 0.
- lb at addr 32'h1003 with response in the first WAIT cycle, rdata=32'h80FFFFFF -> dmem_addr=32'h1000, rmask=4'b1000, wb_rd_v=32'hFFFFFF80, wb_valid 2 cycles after accept. Same access as lbu -> 32'h00000080.
- sh at addr 32'h2002 with data 32'hABCD1234, response delayed 3 cycles -> wmask=4'b1100, wdata=32'h12340000, dmem_* stable for all 3 cycles, mem_stall=1 for 4 cycles, wb_regf_we=0.
- lw at addr 32'h3001 -> no dmem request (masks 0), next cycle wb_valid=1, wb_misalign=1, wb_regf_we=0.
- With TIMEOUT_CYCLES=4 and no response -> timeout_err rises after 4 WAIT cycles and stays high. Asserting rst mid-WAIT -> masks and all outputs 0 immediately, state IDLE, timeout_err cleared.
- Back-to-back load, load, ALU op -> one bubble after each response, and in_order values appear on wb_order in order with no loss or duplication.
